// File: rtl/ahb_rr_slave_arbiter.sv
// Round-robin AHB slave-side arbiter with per-owner beat limit.
// Optional macro AHB_ARB_DYN_PRIOR_EN adds a per-master dynamic priority input.
module ahb_rr_slave_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int MAX_BEATS  = 16,
    parameter int PRIOR_BIT  = 2,
    parameter int IDX_W      = $clog2(MASTER_NUM)
) (
    input  logic                                  hclk,
    input  logic                                  hreset_n,
    input  logic [MASTER_NUM-1:0]                 hreq,
    input  logic [MASTER_NUM-1:0]                 hlast,
    input  logic                                  hwait,
`ifdef AHB_ARB_DYN_PRIOR_EN
    input  logic [MASTER_NUM-1:0][PRIOR_BIT-1:0]  hprior,
`endif
    output logic [MASTER_NUM-1:0]                 hgrant,
    output logic                                  hsel,
    output logic [IDX_W-1:0]                      hmaster
);

    localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LIM =
        (MAX_BEATS > 0) ? CNT_W'(MAX_BEATS - 1) : '0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [MASTER_NUM-1:0]  r_grant;
    logic [MASTER_NUM-1:0]  w_grant_nxt;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic [CNT_W-1:0]       w_beat_cnt_nxt;
    logic [IDX_W-1:0]       r_last_owner;
    logic [IDX_W-1:0]       w_last_owner_nxt;

    logic [IDX_W-1:0]       w_own_idx;
    logic                   w_own;
    logic                   w_accept;
    logic                   w_own_req;
    logic                   w_own_last;
    logic                   w_limit;
    logic                   w_release;
    logic [MASTER_NUM-1:0]  w_others;
    logic [MASTER_NUM-1:0]  w_arb_req;
    logic [IDX_W-1:0]       w_base;
    logic [MASTER_NUM-1:0]  w_win;

    always_comb begin
        w_own_idx = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (r_grant[i]) begin
                w_own_idx = IDX_W'(i);
            end
        end
    end

    assign w_own      = (r_state == S_OWN);
    assign w_accept   = w_own && !hwait;
    assign w_own_req  = |(hreq & r_grant);
    assign w_own_last = |(hlast & r_grant);
    assign w_limit    = (MAX_BEATS != 0) && w_accept && (r_beat_cnt == CNT_LIM);
    assign w_release  = w_own &&
                        ((w_accept && w_own_last) || !w_own_req || w_limit);

    // Releasing owner only competes again when nobody else is asking.
    assign w_others  = hreq & ~r_grant;
    assign w_arb_req = (w_own && (|w_others)) ? w_others : hreq;
    assign w_base    = w_own ? w_own_idx : r_last_owner;

    always_comb begin : arb
        int   j;
        logic found;
`ifdef AHB_ARB_DYN_PRIOR_EN
        logic [PRIOR_BIT-1:0] best;
        best = '0;
`endif
        w_win = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= MASTER_NUM; i++) begin
            j = int'(w_base) + i;
            if (j >= MASTER_NUM) begin
                j = j - MASTER_NUM;
            end
`ifdef AHB_ARB_DYN_PRIOR_EN
            if (w_arb_req[j] && (!found || (hprior[j] > best))) begin
                w_win    = '0;
                w_win[j] = 1'b1;
                best     = hprior[j];
                found    = 1'b1;
            end
`else
            if (w_arb_req[j] && !found) begin
                w_win[j] = 1'b1;
                found    = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_last_owner_nxt = r_last_owner;
        unique case (r_state)
            S_IDLE: begin
                if (|hreq) begin
                    w_state_nxt    = S_OWN;
                    w_grant_nxt    = w_win;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_OWN: begin
                if (w_release) begin
                    w_last_owner_nxt = w_own_idx;
                    w_beat_cnt_nxt   = '0;
                    if (|w_arb_req) begin
                        w_grant_nxt = w_win;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                    end
                end else if (w_accept && (r_beat_cnt < CNT_MAX)) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_last_owner <= IDX_W'(MASTER_NUM - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    assign hgrant  = hwait ? '0 : r_grant;
    assign hsel    = w_own;
    assign hmaster = w_own_idx;

endmodule
